// File: rtl/operand_loader8.sv
// operand_loader8: assembles two serial 8-bit operands into a parallel pair
// for a downstream 8-bit comparator, with abort, hold/acknowledge and
// back-to-back reloading.
module operand_loader8 #(
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic       iClk,
  input  logic       iRst_n,
  input  logic       iStart,
  input  logic       iBitValid,
  input  logic       iSerial,
  input  logic       iAck,
  output logic [7:0] oData_a,
  output logic [7:0] oData_b,
  output logic       oValid,
  output logic       oBusy,
  output logic       oErr
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD_A = 2'd1,
    LOAD_B = 2'd2,
    HOLD   = 2'd3
  } stateT;

  stateT      state;
  stateT      nextState;
  logic [2:0] bitCnt;
  logic [2:0] nextCnt;
  logic [7:0] shiftA;
  logic [7:0] nextShA;
  logic [7:0] shiftB;
  logic [7:0] nextShB;
  logic [7:0] dataA;
  logic [7:0] nextDataA;
  logic [7:0] dataB;
  logic [7:0] nextDataB;
  logic       valid;
  logic       nextValid;
  logic       err;
  logic       nextErr;

  // Inserts one serial bit at the end selected by the bit order, so the
  // first bit received always finishes at bit 7 (MSB first) or bit 0.
  function automatic logic [7:0] shiftIn(input logic [7:0] cur, input logic b);
    if (MSB_FIRST) begin
      return {cur[6:0], b};
    end
    return {b, cur[7:1]};
  endfunction

  // Next-state and next-register decode; oErr defaults low so it only ever
  // pulses for the single cycle following an abort.
  always_comb begin
    nextState = state;
    nextCnt   = bitCnt;
    nextShA   = shiftA;
    nextShB   = shiftB;
    nextDataA = dataA;
    nextDataB = dataB;
    nextValid = valid;
    nextErr   = 1'b0;
    unique case (state)
      IDLE: begin
        if (iStart) begin
          nextState = LOAD_A;
          nextCnt   = 3'd0;
          nextShA   = 8'h00;
          nextShB   = 8'h00;
        end
      end
      LOAD_A: begin
        if (iStart) begin
          nextState = LOAD_A;
          nextCnt   = 3'd0;
          nextShA   = 8'h00;
          nextShB   = 8'h00;
          nextErr   = 1'b1;
        end else if (iBitValid) begin
          nextShA = shiftIn(shiftA, iSerial);
          nextCnt = bitCnt + 3'd1;
          if (bitCnt == 3'd7) begin
            nextState = LOAD_B;
          end
        end
      end
      LOAD_B: begin
        if (iStart) begin
          nextState = LOAD_A;
          nextCnt   = 3'd0;
          nextShA   = 8'h00;
          nextShB   = 8'h00;
          nextErr   = 1'b1;
        end else if (iBitValid) begin
          nextShB = shiftIn(shiftB, iSerial);
          nextCnt = bitCnt + 3'd1;
          if (bitCnt == 3'd7) begin
            nextDataA = shiftA;
            nextDataB = shiftIn(shiftB, iSerial);
            nextValid = 1'b1;
            nextState = HOLD;
          end
        end
      end
      HOLD: begin
        if (iAck) begin
          nextValid = 1'b0;
          if (iStart) begin
            nextState = LOAD_A;
            nextCnt   = 3'd0;
            nextShA   = 8'h00;
            nextShB   = 8'h00;
          end else begin
            nextState = IDLE;
          end
        end
      end
      default: begin
        nextState = IDLE;
      end
    endcase
  end

  // State and datapath registers, all cleared immediately by reset.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state  <= IDLE;
      bitCnt <= 3'd0;
      shiftA <= 8'h00;
      shiftB <= 8'h00;
      dataA  <= 8'h00;
      dataB  <= 8'h00;
      valid  <= 1'b0;
      err    <= 1'b0;
    end else begin
      state  <= nextState;
      bitCnt <= nextCnt;
      shiftA <= nextShA;
      shiftB <= nextShB;
      dataA  <= nextDataA;
      dataB  <= nextDataB;
      valid  <= nextValid;
      err    <= nextErr;
    end
  end

  assign oData_a = dataA;
  assign oData_b = dataB;
  assign oValid  = valid;
  assign oErr    = err;
  assign oBusy   = (state == LOAD_A) || (state == LOAD_B);

endmodule

// File: tb/tb_operand_loader8.sv
// Testbench for operand_loader8: one MSB-first and one LSB-first instance
// share the same stimulus; completed pairs are checked against a queue.
module tb_operand_loader8;

  logic       iClk;
  logic       iRst_n;
  logic       iStart;
  logic       iBitValid;
  logic       iSerial;
  logic       iAck;
  logic [7:0] dataA;
  logic [7:0] dataB;
  logic       valid;
  logic       busy;
  logic       err;
  logic [7:0] lsbDataA;
  logic [7:0] lsbDataB;
  logic       lsbValid;
  logic       lsbBusy;
  logic       lsbErr;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] la;
    logic [7:0] lb;
  } expT;

  expT sb[$];

  operand_loader8 #(.MSB_FIRST(1'b1)) dut (
    .iClk(iClk), .iRst_n(iRst_n), .iStart(iStart), .iBitValid(iBitValid),
    .iSerial(iSerial), .iAck(iAck), .oData_a(dataA), .oData_b(dataB),
    .oValid(valid), .oBusy(busy), .oErr(err)
  );

  operand_loader8 #(.MSB_FIRST(1'b0)) dutLsb (
    .iClk(iClk), .iRst_n(iRst_n), .iStart(iStart), .iBitValid(iBitValid),
    .iSerial(iSerial), .iAck(iAck), .oData_a(lsbDataA), .oData_b(lsbDataB),
    .oValid(lsbValid), .oBusy(lsbBusy), .oErr(lsbErr)
  );

  // Free-running clock
  initial begin
    iClk = 1'b0;
    forever #5 iClk = ~iClk;
  end

  function automatic logic [7:0] rev8(input logic [7:0] v);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = v[7-i];
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic checkFlag(input string tag, input logic observed, input logic expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
    end
  endtask

  // Drives bits v[7-first] .. v[7-last], one per valid cycle, optionally
  // with an idle (junk data) cycle before each valid bit.
  task automatic applyStimulus(input logic [7:0] v, input int first, input int last, input bit gapped);
    for (int i = first; i <= last; i++) begin
      if (gapped) begin
        iBitValid = 1'b0;
        iSerial   = ~v[7-i];
        @(negedge iClk);
      end
      iBitValid = 1'b1;
      iSerial   = v[7-i];
      @(negedge iClk);
    end
    iBitValid = 1'b0;
  endtask

  task automatic pulseStart();
    iStart = 1'b1;
    @(negedge iClk);
    iStart = 1'b0;
  endtask

  // Pops the oldest expected pair and compares both instances against it.
  task automatic scorePair(input string tag);
    expT e;
    checkFlag({tag, "_valid"}, valid, 1'b1);
    checkFlag({tag, "_lsbValid"}, lsbValid, 1'b1);
    checkFlag({tag, "_busy"}, busy, 1'b0);
    checks++;
    assert (sb.size() > 0) else begin
      errors++;
      $error("[TB] FAIL %s_queue observed=empty expected=entry", tag);
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      checkOutput({tag, "_a"}, dataA, e.a);
      checkOutput({tag, "_b"}, dataB, e.b);
      checkOutput({tag, "_lsbA"}, lsbDataA, e.la);
      checkOutput({tag, "_lsbB"}, lsbDataB, e.lb);
    end
  endtask

  // Full pair load; the 16th bit is sent separately so oValid can be
  // shown low before it and high exactly one edge after it.
  task automatic loadPair(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input bit gapped, input bit doStart);
    sb.push_back('{a: a, b: b, la: rev8(a), lb: rev8(b)});
    if (doStart) pulseStart();
    applyStimulus(a, 0, 7, gapped);
    applyStimulus(b, 0, 6, gapped);
    checkFlag({tag, "_validEarly"}, valid, 1'b0);
    applyStimulus(b, 7, 7, gapped);
    scorePair(tag);
  endtask

  task automatic ackPair(input string tag);
    iAck = 1'b1;
    @(negedge iClk);
    iAck = 1'b0;
    checkFlag({tag, "_ackValid"}, valid, 1'b0);
    checkFlag({tag, "_ackBusy"}, busy, 1'b0);
  endtask

  initial begin
    iRst_n    = 1'b0;
    iStart    = 1'b0;
    iBitValid = 1'b0;
    iSerial   = 1'b0;
    iAck      = 1'b0;
    #1;
    checkOutput("rst_a", dataA, 8'h00);
    checkOutput("rst_b", dataB, 8'h00);
    checkFlag("rst_valid", valid, 1'b0);
    checkFlag("rst_busy", busy, 1'b0);
    checkFlag("rst_err", err, 1'b0);
    @(negedge iClk);
    iRst_n = 1'b1;
    @(negedge iClk);

    // Basic contiguous load
    pulseStart();
    checkFlag("basic_busy", busy, 1'b1);
    loadPair("basic", 8'h02, 8'h08, 1'b0, 1'b0);
    ackPair("basic");

    // Gapped load, then iStart alone in HOLD must be ignored
    loadPair("gap", 8'h42, 8'h40, 1'b1, 1'b1);
    iStart = 1'b1;
    @(negedge iClk);
    iStart = 1'b0;
    checkFlag("holdStart_valid", valid, 1'b1);
    checkFlag("holdStart_busy", busy, 1'b0);
    checkFlag("holdStart_err", err, 1'b0);
    checkOutput("holdStart_a", dataA, 8'h42);

    // Back-to-back: ack and start together, old pair held during reload
    iAck   = 1'b1;
    iStart = 1'b1;
    @(negedge iClk);
    iAck   = 1'b0;
    iStart = 1'b0;
    checkFlag("b2b_valid", valid, 1'b0);
    checkFlag("b2b_busy", busy, 1'b1);
    checkFlag("b2b_err", err, 1'b0);
    applyStimulus(8'h24, 0, 3, 1'b0);
    checkOutput("b2b_midA", dataA, 8'h42);
    checkOutput("b2b_midB", dataB, 8'h40);
    applyStimulus(8'h24, 4, 7, 1'b0);
    sb.push_back('{a: 8'h24, b: 8'h24, la: rev8(8'h24), lb: rev8(8'h24)});
    applyStimulus(8'h24, 0, 7, 1'b0);
    scorePair("b2b");
    ackPair("b2b");

    // Reset after 11 bits clears outputs without a clock edge
    pulseStart();
    applyStimulus(8'hA5, 0, 7, 1'b0);
    applyStimulus(8'h5A, 0, 2, 1'b0);
    #2;
    iRst_n = 1'b0;
    #1;
    checkOutput("midRst_a", dataA, 8'h00);
    checkOutput("midRst_b", dataB, 8'h00);
    checkFlag("midRst_valid", valid, 1'b0);
    checkFlag("midRst_busy", busy, 1'b0);
    checkFlag("midRst_err", err, 1'b0);
    @(negedge iClk);
    iRst_n = 1'b1;
    applyStimulus(8'hFF, 0, 7, 1'b0);
    applyStimulus(8'hFF, 0, 7, 1'b0);
    checkFlag("noStart_valid", valid, 1'b0);
    checkFlag("noStart_busy", busy, 1'b0);

    // Stream 0,1,0,0,0,0,0,0 for A: LSB-first instance yields 8'h02
    loadPair("lsb", 8'h40, 8'h81, 1'b0, 1'b1);
    checkOutput("lsb_directA", lsbDataA, 8'h02);
    ackPair("lsb");

    // Abort after 5 bits of A, then full reload without a fresh start
    pulseStart();
    applyStimulus(8'h3C, 0, 4, 1'b0);
    iStart = 1'b1;
    @(negedge iClk);
    iStart = 1'b0;
    checkFlag("abort_err", err, 1'b1);
    checkFlag("abort_busy", busy, 1'b1);
    checkOutput("abort_a", dataA, 8'h40);
    checkOutput("abort_b", dataB, 8'h81);
    @(negedge iClk);
    checkFlag("abort_errPulse", err, 1'b0);
    loadPair("reload", 8'hFF, 8'h00, 1'b0, 1'b0);
    ackPair("reload");

    checks++;
    assert (sb.size() == 0) else begin
      errors++;
      $error("[TB] FAIL leftover observed=%0d expected=0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/operand_loader8.md
OPERAND_LOADER8 -- requirements
Module: operand_loader8

Interface
REQ-001 The block SHALL have one parameter: MSB_FIRST, default 1, 1 = serial operands arrive MSB first and 0 = LSB first.
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset, named as follows:
  iClk      input   1  single clock; all state changes on its rising edge
  iRst_n    input   1  asynchronous, active-low reset
REQ-003 The block SHALL have these further ports:
  iStart    input   1  one-cycle request to begin loading a new operand pair
  iBitValid input   1  qualifies iSerial in the current cycle
  iSerial   input   1  serial operand bit
  iAck      input   1  downstream consumer has taken the presented pair
  oData_a   output  8  parallel operand A for the downstream 8-bit comparator
  oData_b   output  8  parallel operand B for the downstream 8-bit comparator
  oValid    output  1  oData_a/oData_b hold a complete, unacknowledged pair
  oBusy     output  1  high in LOAD_A and LOAD_B
  oErr      output  1  one-cycle pulse on an aborted load (REQ-012)

Function
REQ-004 The block SHALL implement exactly four states: IDLE, LOAD_A, LOAD_B, HOLD.
REQ-005 In IDLE, iStart=1 SHALL move the block to LOAD_A next cycle and clear the 3-bit bit counter and both shift registers.
REQ-006 In LOAD_A/LOAD_B, each cycle with iBitValid=1 SHALL shift iSerial into the A/B shift register and increment the counter; cycles with iBitValid=0 SHALL hold all state.
REQ-007 Bit order:
  - MSB_FIRST=1: shift left, new bit enters bit 0, so the first bit received ends in bit 7.
  - MSB_FIRST=0: shift right, new bit enters bit 7, so the first bit received ends in bit 0.
REQ-008 The 8th valid bit in LOAD_A SHALL switch to LOAD_B with the counter wrapped to 0; no bit SHALL be lost or duplicated across the switch.
REQ-009 The 8th valid bit in LOAD_B SHALL, on that same clock edge, do all of the following:
  - load oData_a from shift register A;
  - load oData_b from shift register B plus the 8th bit;
  - set oValid=1 and enter HOLD.
  Latency from the 16th valid bit to oValid=1 is therefore one edge.
REQ-010 In HOLD, oValid SHALL stay 1 and oData_a/oData_b SHALL stay stable until iAck=1.
  - iAck=1 alone: oValid=0 and return to IDLE next cycle.
  - iAck=1 with iStart=1: oValid=0 and go directly to LOAD_A (back-to-back loading).
REQ-011 oData_a/oData_b SHALL retain the last completed pair after acknowledge and during subsequent loads; they update only per REQ-009.
REQ-012 iStart=1 in LOAD_A or LOAD_B SHALL abort the load:
  - clear the counter and shift registers and restart in LOAD_A;
  - pulse oErr=1 for exactly one cycle;
  - leave oData_a/oData_b unchanged.
REQ-013 iBitValid SHALL be ignored in IDLE and HOLD. iStart SHALL be ignored in HOLD unless iAck=1.
REQ-014 iAck SHALL be ignored when oValid=0.
REQ-015 oBusy SHALL be decoded combinationally from state. All other outputs SHALL be registered.

Reset
REQ-016 iRst_n=0 SHALL immediately, without waiting for a clock edge, force the following:
  - state=IDLE, counter=0, shift registers=0;
  - oData_a=8'h00, oData_b=8'h00;
  - oValid=0, oBusy=0, oErr=0.
REQ-017 Reset asserted mid-load or in HOLD SHALL discard the partial or presented pair. After reset release, the block SHALL wait for a fresh iStart.

Verification
REQ-018 Basic load (MSB_FIRST=1): iStart, then 16 contiguous valid bits for A=8'h02, B=8'h08 -> oValid=1 one edge after the 16th bit, oData_a=8'h02, oData_b=8'h08, oBusy=0; iAck -> oValid=0 and state IDLE.
REQ-019 Gapped bits: A=8'h42, B=8'h40 with iBitValid low on alternate cycles -> same result as contiguous delivery; oValid rises only after the 16th valid bit.
REQ-020 Back-to-back: in HOLD holding 8'h42/8'h40, iAck=1 and iStart=1 together, then load 8'h24/8'h24 -> old pair stays on outputs until the new pair completes; then oData_a=8'h24, oData_b=8'h24, oValid=1.
REQ-021 Abort: iStart after 5 bits of A -> oErr high for exactly one cycle, previous oData_a/oData_b unchanged; a full reload of 8'hFF/8'h00 -> oData_a=8'hFF, oData_b=8'h00.
REQ-022 Reset mid-operation: iRst_n low after 11 bits -> all outputs 0 asynchronously; after release, iBitValid pulses without iStart leave oValid=0.
REQ-023 LSB-first: with MSB_FIRST=0, bit stream 0,1,0,0,0,0,0,0 for A -> oData_a=8'h02.
